// File: rtl/memory_pkg.sv
// Shared memory types for the arbiter and its block-RAM wrapper.
package memory_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;

  typedef logic [ADDR_WIDTH-1:0] mem_addr_t;
  typedef logic [DATA_WIDTH-1:0] mem_word_t;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;
endpackage

// File: rtl/mem_ram_core.sv
// Inferable single-port RAM with registered read, in the vendor inference template.
// No reset on the array or the read register so it maps onto a block-RAM primitive.
module mem_ram_core #(
  parameter int ADDR_WIDTH = memory_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = memory_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we)
      ram[addr] <= wdata;
    if (re)
      q <= ram[addr];
  end
endmodule

// File: rtl/altera_memory_wrapper.sv
// Request/response wrapper around mem_ram_core: 1-cycle read with data_ready strobe, write wins on collision.
// Optional power-up clear sweep under ALTERA_MEMORY_WRAPPER_CLEAR_EN (busy high during the sweep).
module altera_memory_wrapper #(
  parameter int ADDR_WIDTH = memory_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = memory_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  data_ready,
  output logic                  busy
);
  import memory_pkg::*;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  out_vld;
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [DATA_WIDTH-1:0] core_q;

  assign wr_acc = wr_enable & ~busy;
  assign rd_acc = rd_enable & ~wr_enable & ~busy;

`ifdef ALTERA_MEMORY_WRAPPER_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  clr_state_t            clr_state;
  logic [ADDR_WIDTH-1:0] clr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_state <= CLR_CLEAR;
      clr_addr  <= '0;
    end else if (clr_state == CLR_CLEAR) begin
      clr_addr <= clr_addr + ADDR_ONE;
      if (&clr_addr)
        clr_state <= CLR_IDLE;
    end
  end

  assign busy       = (clr_state == CLR_CLEAR);
  assign core_we    = busy | wr_acc;
  assign core_addr  = busy ? clr_addr : addr;
  assign core_wdata = busy ? '0 : wr_data;
`else
  assign busy       = 1'b0;
  assign core_we    = wr_acc;
  assign core_addr  = addr;
  assign core_wdata = wr_data;
`endif

  mem_ram_core #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .clk  (clk),
    .we   (core_we),
    .re   (rd_acc),
    .addr (core_addr),
    .wdata(core_wdata),
    .q    (core_q)
  );

  // The RAM read register cannot be reset, so out_vld masks it to zero until the first read after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_ready <= 1'b0;
      out_vld    <= 1'b0;
    end else begin
      data_ready <= rd_acc;
      if (rd_acc)
        out_vld <= 1'b1;
    end
  end

  assign rd_data = out_vld ? core_q : '0;
endmodule

// File: tb/tb_altera_memory_wrapper.sv
// Scoreboard bench for altera_memory_wrapper; clear-sweep checks build with ALTERA_MEMORY_WRAPPER_CLEAR_EN.
module tb_altera_memory_wrapper;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr = '0;
  logic        wr_enable = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_enable = 1'b0;
  logic [15:0] rd_data;
  logic        data_ready;
  logic        busy;

  altera_memory_wrapper dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wr_enable (wr_enable),
    .wr_data   (wr_data),
    .rd_enable (rd_enable),
    .rd_data   (rd_data),
    .data_ready(data_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] model [256];
  logic [15:0] sb [$];
  int          rdy_run = 0;
  int          max_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request for one clock; reads that will be accepted push their expected word.
  task automatic do_cycle(input bit we, input bit re, input logic [7:0] a, input logic [15:0] d);
    addr = a; wr_data = d; wr_enable = we; rd_enable = re;
    if (re && !we) sb.push_back(model[a]);
    if (we) model[a] = d;
    @(posedge clk); #1;
    wr_enable = 1'b0; rd_enable = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (2) do_cycle(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq(tag, sb.size(), 0);
  endtask

  task automatic wait_not_busy(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_ready) begin
        rdy_run++;
        if (rdy_run > max_run) max_run = rdy_run;
        if (sb.size() == 0) check_eq("spurious_data_ready", 1, 0);
        else check_eq("rd_data", rd_data, sb.pop_front());
      end else begin
        rdy_run = 0;
      end
    end
  end

  initial begin
`ifdef ALTERA_MEMORY_WRAPPER_CLEAR_EN
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
`else
    for (int i = 0; i < 256; i++) model[i] = 16'hxxxx;
`endif
    #12;
    check_eq("reset_rd_data", rd_data, 16'h0000);
    check_eq("reset_data_ready", data_ready, 1'b0);
`ifdef ALTERA_MEMORY_WRAPPER_CLEAR_EN
    check_eq("reset_busy", busy, 1'b1);
`else
    check_eq("reset_busy", busy, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

`ifdef ALTERA_MEMORY_WRAPPER_CLEAR_EN
    begin
      int cnt = 0;
      while (busy && cnt < 1000) begin
        cnt++;
        // A write to an already swept address while busy must not stick.
        if (cnt == 5) begin addr = 8'h00; wr_data = 16'hBEEF; wr_enable = 1'b1; end
        else wr_enable = 1'b0;
        @(negedge clk);
      end
      wr_enable = 1'b0;
      check_eq("busy_cycles", cnt, 256);
    end
    for (int i = 0; i < 256; i++) do_cycle(1'b0, 1'b1, i[7:0], 16'h0000);
    drain("clear_sweep_drain");
`endif

    // Single write then read.
    do_cycle(1'b1, 1'b0, 8'h00, 16'h1111);
    max_run = 0;
    do_cycle(1'b0, 1'b1, 8'h00, 16'h0000);
    drain("single_read_drain");
    check_eq("single_strobe_len", max_run, 1);

    // Fill low block and two high addresses, then spot reads.
    for (int i = 1; i < 6; i++) do_cycle(1'b1, 1'b0, i[7:0], 16'(16'h1111 * (i + 1)));
    do_cycle(1'b1, 1'b0, 8'h80, 16'h7777);
    do_cycle(1'b1, 1'b0, 8'h81, 16'h8888);
    do_cycle(1'b0, 1'b1, 8'h00, 16'h0000);
    do_cycle(1'b0, 1'b0, 8'h00, 16'h0000);
    do_cycle(1'b0, 1'b1, 8'h80, 16'h0000);
    do_cycle(1'b0, 1'b1, 8'h81, 16'h0000);
    do_cycle(1'b1, 1'b0, 8'hFF, 16'hF00D);
    do_cycle(1'b0, 1'b1, 8'hFF, 16'h0000);
    drain("spot_read_drain");

    // Back-to-back burst.
    max_run = 0;
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, i[7:0], 16'h0000);
    drain("burst_drain");
    check_eq("burst_strobe_run", max_run, 6);

    // Collision: write wins, read dropped.
    do_cycle(1'b1, 1'b1, 8'h03, 16'hABCD);
    drain("collision_no_ready");
    do_cycle(1'b0, 1'b1, 8'h03, 16'h0000);
    drain("collision_readback");

    // Reset while a read result is on the bus.
    do_cycle(1'b1, 1'b0, 8'h40, 16'h5A5A);
    addr = 8'h00; rd_enable = 1'b1;
    @(posedge clk); #1;
    rd_enable = 1'b0;
    check_eq("pre_rst_ready", data_ready, 1'b1);
    check_eq("pre_rst_data", rd_data, {16'h1111});
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", data_ready, 1'b0);
    check_eq("mid_rst_data", rd_data, 16'h0000);
    rst = 1'b0;
`ifdef ALTERA_MEMORY_WRAPPER_CLEAR_EN
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    wait_not_busy("post_rst_sweep_done");
`endif
    @(negedge clk);
    do_cycle(1'b0, 1'b1, 8'h40, 16'h0000);
    do_cycle(1'b0, 1'b1, 8'h05, 16'h0000);
    drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
